// File: rtl/deser400_tx_emulator.sv
// 4b/5b + NRZI test-pattern transmitter for the deser400 input path.
// Emits one 8-sample word per line bit, with the edge placed at a programmable 1/8-bit position.
module deser400_tx_emulator #(
  parameter logic [4:0] IDLE_SYM = 5'b11111
) (
  input  logic       clk,
  input  logic       res,
  input  logic       enable,
  input  logic [2:0] phase,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] samples,
  output logic       line,
  output logic       sym_start
);

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] sym;
    case (nib)
      4'h0: sym = 5'b11110;
      4'h1: sym = 5'b01001;
      4'h2: sym = 5'b10100;
      4'h3: sym = 5'b10101;
      4'h4: sym = 5'b01010;
      4'h5: sym = 5'b01011;
      4'h6: sym = 5'b01110;
      4'h7: sym = 5'b01111;
      4'h8: sym = 5'b10010;
      4'h9: sym = 5'b10011;
      4'hA: sym = 5'b10110;
      4'hB: sym = 5'b10111;
      4'hC: sym = 5'b11010;
      4'hD: sym = 5'b11011;
      4'hE: sym = 5'b11100;
      default: sym = 5'b11101;
    endcase
    return sym;
  endfunction

  // Samples before the phase index still show the old level; the rest show the new one.
  function automatic logic [7:0] place_edge(input logic lvl_old, input logic lvl_new,
                                            input logic [2:0] ph);
    logic [7:0] word;
    for (int i = 0; i < 8; i++) begin
      word[i] = (i < int'(ph)) ? lvl_old : lvl_new;
    end
    return word;
  endfunction

  logic [2:0] r_bit_cnt;
  logic [4:0] r_shift;
  logic [2:0] r_phase;
  logic       r_line;
  logic [7:0] r_samples;
  logic       r_sym_start;

  logic       w_boundary;
  logic       w_bit;
  logic       w_new_level;

  assign w_boundary  = enable & ~res & (r_bit_cnt == 3'd4);
  assign w_bit       = r_shift[4];
  assign w_new_level = r_line ^ w_bit;

  assign din_ready = w_boundary;
  assign samples   = r_samples;
  assign line      = r_line;
  assign sym_start = r_sym_start;

  // Bit stage: emit the current MSB, reload the shift register at the symbol boundary.
  always_ff @(posedge clk) begin
    if (res) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= IDLE_SYM;
      r_phase     <= 3'd0;
      r_line      <= 1'b0;
      r_samples   <= 8'h00;
      r_sym_start <= 1'b0;
    end else if (!enable) begin
      r_samples   <= {8{r_line}};
      r_sym_start <= 1'b0;
    end else begin
      r_samples   <= place_edge(r_line, w_new_level, r_phase);
      r_line      <= w_new_level;
      r_sym_start <= (r_bit_cnt == 3'd0);
      if (w_boundary) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= din_valid ? enc_4b5b(din) : IDLE_SYM;
        r_phase   <= phase;
      end else begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {r_shift[3:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_deser400_tx_emulator.sv
// Self-checking bench for deser400_tx_emulator: directed scenarios followed by random traffic,
// compared against a bit-queue model of the transmitted line.
module tb_deser400_tx_emulator;

  logic       clk;
  logic       res;
  logic       enable;
  logic [2:0] phase;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] samples;
  logic       line;
  logic       sym_start;

  deser400_tx_emulator dut (
    .clk       (clk),
    .res       (res),
    .enable    (enable),
    .phase     (phase),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .samples   (samples),
    .line      (line),
    .sym_start (sym_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] code_tab [16];
  bit         bitq [$];
  int         en_cnt;
  logic       m_line;
  logic [2:0] m_phase;
  logic       lh [$];

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [4:0] sym);
    for (int k = 4; k >= 0; k--) bitq.push_back(sym[k]);
  endtask

  // One clock: drive inputs, check din_ready, advance the model, check registered outputs.
  task automatic step(input logic r, input logic e, input logic [2:0] ph,
                      input logic v, input logic [3:0] d, output logic acc);
    logic       exp_rdy;
    logic [7:0] exp_s;
    logic       exp_ss;
    logic       b;
    logic       nl;
    int         pos;
    res = r; enable = e; phase = ph; din_valid = v; din = d;
    #1;
    pos     = en_cnt % 5;
    exp_rdy = !r && e && (pos == 4);
    chk1("din_ready", din_ready, exp_rdy);
    acc = exp_rdy && v;
    if (r) begin
      m_line = 1'b0; exp_s = 8'h00; exp_ss = 1'b0;
      en_cnt = 0; m_phase = 3'd0;
      bitq.delete();
      push_sym(5'b11111);
    end else if (!e) begin
      exp_s  = {8{m_line}};
      exp_ss = 1'b0;
    end else begin
      b  = bitq.pop_front();
      nl = m_line ^ b;
      for (int i = 0; i < 8; i++) exp_s[i] = (i < int'(m_phase)) ? m_line : nl;
      exp_ss = (pos == 0);
      m_line = nl;
      if (pos == 4) begin
        push_sym(v ? code_tab[d] : 5'b11111);
        m_phase = ph;
      end
      en_cnt++;
    end
    @(posedge clk);
    #1;
    chk8("samples", samples, exp_s);
    chk1("line", line, m_line);
    chk1("sym_start", sym_start, exp_ss);
    lh.push_back(line);
  endtask

  initial begin
    logic       acc;
    logic [7:0] w0 [5];
    logic [3:0] src [$];
    logic [9:0] exp_bits;
    int         base;
    int         acc_a;
    int         acc_b;
    int         nacc;
    int         got;
    int         k;

    code_tab = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                 5'b01010, 5'b01011, 5'b01110, 5'b01111,
                 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    en_cnt = 0; m_line = 1'b0; m_phase = 3'd0;
    res = 1'b1; enable = 1'b1; phase = 3'd0; din = 4'd0; din_valid = 1'b0;

    // Reset for two cycles with a nibble offered: it must not be taken.
    step(1'b1, 1'b1, 3'd0, 1'b1, 4'h7, acc);
    step(1'b1, 1'b1, 3'd0, 1'b0, 4'h0, acc);
    chk8("reset_samples", samples, 8'h00);
    chk1("reset_line", line, 1'b0);

    // Idle first symbol, then nibble 0 offered from cycle 6 and taken at the 10th boundary cycle.
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 3'd0, 1'b0, 4'h0, acc);
    chk1("first_ready_gone", din_ready, 1'b0);
    got = 0;
    for (int i = 6; i <= 10 && got == 0; i++) begin
      step(1'b0, 1'b1, 3'd0, 1'b1, 4'h0, acc);
      if (acc) begin
        got = i;
        chk1("line_before_nib0", line, 1'b0);
      end
    end
    chk8("nib0_accept_cycle", 8'(got), 8'd10);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 3'd3, 1'b0, 4'h0, acc);
      w0[i] = samples;
    end
    chk8("nib0_w0", w0[0], 8'hFF);
    chk8("nib0_w1", w0[1], 8'h00);
    chk8("nib0_w2", w0[2], 8'hFF);
    chk8("nib0_w3", w0[3], 8'h00);
    chk8("nib0_w4", w0[4], 8'h00);
    chk1("nib0_end_line", line, 1'b0);

    // Phase 3 captured at that boundary; a mid-symbol change to 5 waits for the next boundary.
    step(1'b0, 1'b1, 3'd3, 1'b0, 4'h0, acc);
    chk8("phase3_rise", samples, 8'hF8);
    step(1'b0, 1'b1, 3'd5, 1'b0, 4'h0, acc);
    chk8("phase3_fall", samples, 8'h07);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd5, 1'b0, 4'h0, acc);

    // Back-to-back 0xA then 0x5 with valid held by the source.
    src = '{4'hA, 4'h5};
    base = -1; acc_a = -1; acc_b = -1; nacc = 0;
    for (int i = 0; i < 30; i++) begin
      if (src.size() > 0) step(1'b0, 1'b1, 3'd0, 1'b1, src[0], acc);
      else                step(1'b0, 1'b1, 3'd0, 1'b0, 4'h0, acc);
      if (acc) begin
        void'(src.pop_front());
        nacc++;
        if (nacc == 1) begin
          acc_a = i;
          base  = lh.size() - 1;
        end else acc_b = i;
      end
    end
    chk8("b2b_gap", 8'(acc_b - acc_a), 8'd5);
    exp_bits = 10'b1011001011;
    if (base >= 0 && lh.size() > base + 10) begin
      for (int j = 1; j <= 10; j++)
        chk1("nrzi_decode", lh[base + j] ^ lh[base + j - 1], exp_bits[10 - j]);
    end else begin
      chk1("b2b_accepted", 1'b0, 1'b1);
    end

    // Freeze three cycles while bit_cnt is 2, then resume.
    k = 0;
    while (en_cnt % 5 != 2 && k < 10) begin
      step(1'b0, 1'b1, 3'd2, 1'b0, 4'h0, acc);
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'd2, 1'b1, 4'h9, acc);
      chk8("frozen_flat", samples, {8{line}});
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 3'd2, 1'b1, 4'h9, acc);

    // Random traffic with occasional freezes and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom), acc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
